fifo_drain_sequencer: RTL and testbench

- Controller on the pop side of the multi-push/multi-pop UART FIFO (W-bit words, up to N pops per cycle).
- Decides how many words to pop each time, latches the popped group into a local buffer, and replays it one word per handshake to a single-word consumer (UART TX byte input).
- Batching lets the FIFO run wide while the serial transmitter stays narrow.

---
 rtl/fifo_drain_pkg.sv | 18 +
 rtl/fifo_drain_sequencer_if.sv | 32 +++
 rtl/fifo_drain_sequencer.sv | 135 +++++++++++++
 tb/tb_fifo_drain_sequencer.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_drain_pkg.sv
// fifo_drain_pkg: shared types and helpers for fifo_drain_sequencer.
//   drain_state_t : sequencer FSM states (IDLE, SEND)
//   STATS_W       : width of the optional statistics counters
//   min_count     : minimum of two word counts
package fifo_drain_pkg;

    typedef enum logic {
        IDLE,
        SEND
    } drain_state_t;

    localparam int unsigned STATS_W = 16;

    function automatic int unsigned min_count(input int unsigned a, input int unsigned b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/fifo_drain_sequencer_if.sv
// fifo_drain_sequencer_if: pop-side FIFO signals plus the single-word output stream.
//   can_pop   : words available in the FIFO, saturated at N
//   pop       : words popped on this clk edge
//   pop_data  : show-ahead FIFO head, index 0 oldest
//   burst_max : configured maximum words per pop (0 or >N means N)
//   out_valid / out_ready / out_data : single-word valid/ready stream
//   busy      : sequencer is replaying a buffered group
// Modports: master = sequencer side, slave = FIFO/consumer side.
interface fifo_drain_sequencer_if #(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int WN = $clog2(N + 1)
);
    logic [WN-1:0]       can_pop;
    logic [WN-1:0]       pop;
    logic [N-1:0][W-1:0] pop_data;
    logic [WN-1:0]       burst_max;
    logic                out_valid;
    logic                out_ready;
    logic [W-1:0]        out_data;
    logic                busy;

    modport master (
        input  can_pop, pop_data, burst_max, out_ready,
        output pop, out_valid, out_data, busy
    );

    modport slave (
        output can_pop, pop_data, burst_max, out_ready,
        input  pop, out_valid, out_data, busy
    );
endinterface

// File: rtl/fifo_drain_sequencer.sv
// fifo_drain_sequencer: pops up to N words at a time from a multi-pop FIFO,
// buffers the group locally and replays it one word per handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : fifo_drain_sequencer_if.master (FIFO pop side + output stream)
//   word_cnt : output handshakes counted (FIFO_DRAIN_STATS_EN only)
//   pop_ops  : cycles with pop != 0 counted (FIFO_DRAIN_STATS_EN only)
// Optional feature macro: FIFO_DRAIN_STATS_EN.
module fifo_drain_sequencer
    import fifo_drain_pkg::*;
#(
    parameter int W  = 8,
    parameter int N  = 4,
    parameter int WN = $clog2(N + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    fifo_drain_sequencer_if.master   bus
`ifdef FIFO_DRAIN_STATS_EN
    ,
    output logic [STATS_W-1:0]       word_cnt,
    output logic [STATS_W-1:0]       pop_ops
`endif
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;
    localparam logic [WN-1:0] CNT_ONE = WN'(1);
    localparam logic [IW-1:0] IDX_ONE = IW'(1);

    drain_state_t        state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [WN-1:0]       cnt_q, cnt_d;
    logic [N-1:0][W-1:0] buf_q, buf_d;

    logic [WN-1:0] lim;
    logic [WN-1:0] take;
    logic          hs;
    logic          last;
    logic          load;
    logic [WN-1:0] pop_w;

    // take depends only on can_pop and burst_max, never on pop_data
    always_comb begin
        lim  = ((bus.burst_max == '0) || (32'(bus.burst_max) > 32'(N))) ? WN'(N) : bus.burst_max;
        take = WN'(min_count(32'(bus.can_pop), 32'(lim)));
    end

    assign hs   = (state_q == SEND) && bus.out_ready;
    assign last = (WN'(idx_q) == (cnt_q - CNT_ONE));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        load    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (take != '0) begin
                    load    = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (hs) begin
                    if (!last) begin
                        idx_d = idx_q + IDX_ONE;
                    end else if (take != '0) begin
                        // zero-bubble refill: pop while the last word is accepted
                        load = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            cnt_d = take;
            idx_d = '0;
            for (int unsigned i = 0; i < N; i++) begin
                if (i < 32'(take)) begin
                    buf_d[i] = bus.pop_data[i];
                end
            end
        end

        pop_w = (load && !rst) ? take : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
        end
    end

    assign bus.pop       = pop_w;
    assign bus.out_valid = (state_q == SEND);
    assign bus.busy      = (state_q == SEND);
    assign bus.out_data  = buf_q[idx_q];

`ifdef FIFO_DRAIN_STATS_EN
    localparam logic [STATS_W-1:0] STAT_ONE = STATS_W'(1);

    logic [STATS_W-1:0] word_cnt_q;
    logic [STATS_W-1:0] pop_ops_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_cnt_q <= '0;
            pop_ops_q  <= '0;
        end else begin
            if (hs) begin
                word_cnt_q <= word_cnt_q + STAT_ONE;
            end
            if (pop_w != '0) begin
                pop_ops_q <= pop_ops_q + STAT_ONE;
            end
        end
    end

    assign word_cnt = word_cnt_q;
    assign pop_ops  = pop_ops_q;
`endif

endmodule

// File: tb/tb_fifo_drain_sequencer.sv
// tb_fifo_drain_sequencer: self-checking bench for fifo_drain_sequencer.
// The FIFO is a bench queue; the sequencer is modelled as a queue of words
// still owed to the consumer. A refill is due whenever that queue is empty
// or its final word is being accepted. Honours FIFO_DRAIN_STATS_EN.
module tb_fifo_drain_sequencer;

    localparam int W  = 8;
    localparam int N  = 4;
    localparam int WN = 3;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    fifo_drain_sequencer_if #(.W(W), .N(N), .WN(WN)) bus ();

`ifdef FIFO_DRAIN_STATS_EN
    logic [15:0] word_cnt;
    logic [15:0] pop_ops;
`endif

    fifo_drain_sequencer #(.W(W), .N(N), .WN(WN)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef FIFO_DRAIN_STATS_EN
        ,
        .word_cnt (word_cnt),
        .pop_ops  (pop_ops)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] mbuf[$];
    logic [7:0] seen[$];
    int unsigned bmax;
    bit          ready;
    int unsigned m_words;
    int unsigned m_pops;

    int unsigned s_pop;
    int unsigned s_valid;
    int unsigned s_busy;
    int unsigned s_data;

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare with the model, advance at posedge.
    task automatic step();
        int unsigned cp, lim, take, exp_pop;
        @(negedge clk);
        cp = (fifo_q.size() > N) ? N : fifo_q.size();
        bus.can_pop   = WN'(cp);
        for (int i = 0; i < N; i++) begin
            bus.pop_data[i] = (i < fifo_q.size()) ? fifo_q[i] : 8'($urandom);
        end
        bus.burst_max = WN'(bmax);
        bus.out_ready = ready;
        #1;
        lim     = (bmax == 0 || bmax > N) ? N : bmax;
        take    = (cp < lim) ? cp : lim;
        exp_pop = (mbuf.size() == 0 || (mbuf.size() == 1 && ready)) ? take : 0;

        s_pop   = bus.pop;
        s_valid = bus.out_valid;
        s_busy  = bus.busy;
        s_data  = bus.out_data;

        check("pop", s_pop, exp_pop);
        check("out_valid", s_valid, (mbuf.size() != 0) ? 1 : 0);
        check("busy", s_busy, (mbuf.size() != 0) ? 1 : 0);
        if (mbuf.size() != 0) check("out_data", s_data, mbuf[0]);
`ifdef FIFO_DRAIN_STATS_EN
        check("word_cnt", word_cnt, m_words & 16'hFFFF);
        check("pop_ops", pop_ops, m_pops & 16'hFFFF);
`endif
        @(posedge clk);
        if (mbuf.size() != 0 && ready) begin
            seen.push_back(mbuf.pop_front());
            m_words++;
        end
        if (exp_pop != 0) m_pops++;
        for (int k = 0; k < int'(exp_pop); k++) mbuf.push_back(fifo_q.pop_front());
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.can_pop   = '0;
        bus.pop_data  = '0;
        bus.burst_max = '0;
        bus.out_ready = 1'b0;
        mbuf.delete();
        fifo_q.delete();
        seen.delete();
        m_words = 0;
        m_pops  = 0;
        @(negedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_pop", bus.pop, 0);
`ifdef FIFO_DRAIN_STATS_EN
        check("rst_word_cnt", word_cnt, 0);
        check("rst_pop_ops", pop_ops, 0);
`endif
        rst = 1'b0;
    endtask

    initial begin
        rst   = 1'b1;
        bmax  = 0;
        ready = 1'b0;

        // Basic: 1,2,3 with burst_max=0
        do_reset();
        bmax = 0; ready = 1'b1;
        fifo_q = '{8'd1, 8'd2, 8'd3};
        step(); check("basic_pop", s_pop, 3);
        step(); check("basic_w0", s_data, 1);
        step(); check("basic_w1", s_data, 2);
        step(); check("basic_w2", s_data, 3);
        step(); check("basic_idle_valid", s_valid, 0); check("basic_idle_pop", s_pop, 0);

        // Clamp: burst_max=2 over 6,7,8,9
        do_reset();
        bmax = 2; ready = 1'b1;
        fifo_q = '{8'd6, 8'd7, 8'd8, 8'd9};
        step(); check("clamp_pop0", s_pop, 2);
        step(); check("clamp_w6", s_data, 6); check("clamp_pop_w6", s_pop, 0);
        step(); check("clamp_w7", s_data, 7); check("clamp_pop_w7", s_pop, 2);
        step(); check("clamp_w8", s_data, 8);
        step(); check("clamp_w9", s_data, 9); check("clamp_pop_w9", s_pop, 0);
        step(); check("clamp_idle", s_valid, 0);

        // Backpressure: ready 1,0,0,1 over A5,5A
        do_reset();
        bmax = 0; ready = 1'b1;
        fifo_q = '{8'hA5, 8'h5A};
        step(); check("bp_pop", s_pop, 2);
        step(); check("bp_w0", s_data, 8'hA5);
        ready = 1'b0;
        step(); check("bp_stall1", s_data, 8'h5A); check("bp_stall1_pop", s_pop, 0);
        step(); check("bp_stall2", s_data, 8'h5A); check("bp_stall2_pop", s_pop, 0);
        ready = 1'b1;
        step(); check("bp_w1", s_data, 8'h5A);
        step(); check("bp_idle", s_valid, 0);
        check("bp_count", seen.size(), 2);

        // Empty FIFO
        do_reset();
        for (int c = 0; c < 20; c++) begin
            bmax  = $urandom_range(0, 7);
            ready = 1'($urandom_range(0, 1));
            step();
            check("empty_pop", s_pop, 0);
            check("empty_valid", s_valid, 0);
            check("empty_busy", s_busy, 0);
        end

        // Reset mid-burst
        do_reset();
        bmax = 0; ready = 1'b1;
        fifo_q = '{8'hC1, 8'hC2, 8'hC3, 8'hC4};
        step(); check("mid_pop", s_pop, 4);
        step(); check("mid_w0", s_data, 8'hC1);
        #3;
        fifo_q.delete();
        fifo_q.push_back(8'h11);
        bus.can_pop     = WN'(1);
        bus.pop_data[0] = 8'h11;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", bus.out_valid, 0);
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_data", bus.out_data, 0);
        check("mid_rst_pop", bus.pop, 0);
        mbuf.delete();
        m_words = 0;
        m_pops  = 0;
        @(posedge clk);
        #1;
        check("mid_rst_pop_edge", bus.pop, 0);
        #1;
        rst = 1'b0;
        step(); check("mid_refill_pop", s_pop, 1);
        step(); check("mid_first_valid", s_valid, 1); check("mid_first_data", s_data, 8'h11);
        step();

`ifdef FIFO_DRAIN_STATS_EN
        // Stats: 10 words, burst_max=4
        do_reset();
        bmax = 4; ready = 1'b1;
        for (int k = 0; k < 10; k++) fifo_q.push_back(8'(k + 1));
        repeat (12) step();
        check("stats_word_cnt", word_cnt, 10);
        check("stats_pop_ops", pop_ops, 3);
`endif

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (fifo_q.size() < 12 && $urandom_range(0, 2) != 0) begin
                int unsigned n = $urandom_range(0, 3);
                for (int k = 0; k < int'(n); k++) fifo_q.push_back(8'($urandom));
            end
            if ($urandom_range(0, 7) == 0) bmax = $urandom_range(0, 7);
            ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
